// File: rtl/raster_step_gen.sv
// Raster-order (dx, dy) coordinate generator with valid/ready output, abort and done pulse.
// Optional macro RASTER_STEP_GEN_SERPENTINE_EN: odd rows traverse X descending.
module raster_step_gen #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WIDTH-1:0]        cfg_max_x,
  input  logic [HEIGHT-1:0]       cfg_max_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_dx,
  output logic [HEIGHT-1:0]       out_dy,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH+HEIGHT-1:0] beat_count
);
  localparam int CW = WIDTH + HEIGHT;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_x, r_max_x, w_x_nxt;
  logic [HEIGHT-1:0] r_y, r_max_y, w_y_nxt;
  logic [CW-1:0]     r_beat_count;
  logic              w_xfer, w_row_end, w_last;

  assign w_xfer = (r_state == S_RUN) && out_ready;

`ifdef RASTER_STEP_GEN_SERPENTINE_EN
  // Odd rows walk right-to-left; x stays put across the row change.
  logic w_odd;
  assign w_odd     = r_y[0];
  assign w_row_end = w_odd ? (r_x == '0) : (r_x == r_max_x);
  assign w_last    = (r_y == r_max_y) &&
                     (r_x == (r_max_y[0] ? {WIDTH{1'b0}} : r_max_x));
  assign w_x_nxt   = w_row_end ? r_x : (w_odd ? r_x - WIDTH'(1) : r_x + WIDTH'(1));
`else
  assign w_row_end = (r_x == r_max_x);
  assign w_last    = w_row_end && (r_y == r_max_y);
  assign w_x_nxt   = w_row_end ? '0 : r_x + WIDTH'(1);
`endif
  assign w_y_nxt   = w_row_end ? r_y + HEIGHT'(1) : r_y;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        // abort wins even when the aborting beat is the last one
        if (abort)               w_state_nxt = S_IDLE;
        else if (w_xfer && w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_max_x      <= '0;
      r_max_y      <= '0;
      r_beat_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_max_x      <= cfg_max_x;
        r_max_y      <= cfg_max_y;
        r_x          <= '0;
        r_y          <= '0;
        r_beat_count <= '0;
      end else if (w_xfer) begin
        if (r_beat_count != '1) r_beat_count <= r_beat_count + CW'(1);
        if (!w_last) begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
        end
      end
    end
  end

  assign out_valid  = (r_state == S_RUN);
  assign out_dx     = r_x;
  assign out_dy     = r_y;
  assign out_last   = (r_state == S_RUN) && w_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign beat_count = r_beat_count;
endmodule

// File: tb/tb_raster_step_gen.sv
// Scoreboard bench for raster_step_gen: expected beats queued at start, popped on each transfer.
module tb_raster_step_gen;
  localparam int WIDTH  = 10;
  localparam int HEIGHT = 11;

  typedef struct packed {
    logic [WIDTH-1:0]  dx;
    logic [HEIGHT-1:0] dy;
    logic              last;
  } beat_t;

  logic                    clock = 0;
  logic                    reset = 1;
  logic                    start = 0;
  logic                    abort = 0;
  logic [WIDTH-1:0]        cfg_max_x = '0;
  logic [HEIGHT-1:0]       cfg_max_y = '0;
  logic                    out_valid;
  logic                    out_ready = 0;
  logic [WIDTH-1:0]        out_dx;
  logic [HEIGHT-1:0]       out_dy;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  logic [WIDTH+HEIGHT-1:0] beat_count;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  raster_step_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_max_x(cfg_max_x), .cfg_max_y(cfg_max_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dx(out_dx), .out_dy(out_dy), .out_last(out_last),
    .busy(busy), .done(done), .beat_count(beat_count)
  );

  always #5 clock = ~clock;

  // Scoreboard: every transfer must match the next queued beat.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      beat_t got, exp;
      got = '{dx: out_dx, dy: out_dy, last: out_last};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got dx=%0d dy=%0d last=%0d, required none", out_dx, out_dy, out_last);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat got dx=%0d dy=%0d last=%0d, required dx=%0d dy=%0d last=%0d",
                   got.dx, got.dy, got.last, exp.dx, exp.dy, exp.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Reference scan order; pushes the first n beats (n<0: all).
  task automatic push_scan(input int mx, input int my, input int n);
    int cnt = 0;
    for (int y = 0; y <= my; y++)
      for (int i = 0; i <= mx; i++) begin
        beat_t b;
        int x = i;
`ifdef RASTER_STEP_GEN_SERPENTINE_EN
        if (y % 2 == 1) x = mx - i;
`endif
        b.dx = WIDTH'(x); b.dy = HEIGHT'(y);
        b.last = (y == my) && (i == mx);
        if (n < 0 || cnt < n) sb.push_back(b);
        cnt++;
      end
  endtask

  task automatic do_start(input int mx, input int my, input int n);
    cfg_max_x = WIDTH'(mx); cfg_max_y = HEIGHT'(my);
    start = 1;
    push_scan(mx, my, n);
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    @(negedge clock);
    checks++;
    if (out_valid !== 0 || busy !== 0 || done !== 0 || beat_count !== 0) begin
      errors++;
      $display("FAIL reset got v=%0b busy=%0b done=%0b cnt=%0d, required 0 0 0 0", out_valid, busy, done, beat_count);
    end
    tick();
    reset = 0;
  endtask

  task automatic test_basic(input int mx, input int my, input string nm);
    bit seen = 0, prev_last = 0;
    int nb = (mx + 1) * (my + 1);
    out_ready = 1;
    do_start(mx, my, -1);
    @(negedge clock);
    checks++;
    if (out_valid !== 1) begin
      errors++; $display("FAIL %s_latency got valid=%0b, required 1", nm, out_valid);
    end
    for (int c = 0; c < 100 && !seen; c++) begin
      if (done) begin
        seen = 1;
        checks++;
        if (prev_last !== 1) begin
          errors++; $display("FAIL %s_done_timing got prev_last=%0b, required 1", nm, prev_last);
        end
      end else begin
        prev_last = out_valid && out_ready && out_last;
        @(negedge clock);
      end
    end
    checks++;
    if (!seen || beat_count !== nb) begin
      errors++; $display("FAIL %s_count got done=%0b cnt=%0d, required 1 %0d", nm, seen, beat_count, nb);
    end
    @(negedge clock);
    checks++;
    if (done !== 0 || busy !== 0 || sb.size() !== 0) begin
      errors++; $display("FAIL %s_end got done=%0b busy=%0b left=%0d, required 0 0 0", nm, done, busy, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    bit seen = 0, pv = 0, pr = 0, hold_ok = 1;
    logic [WIDTH-1:0] px = '0;
    logic [HEIGHT-1:0] py = '0;
    out_ready = 0;
    do_start(3, 0, -1);
    for (int c = 0; c < 40 && !seen; c++) begin
      out_ready = pat[c % 4];
      @(negedge clock);
      if (pv && !pr && (out_valid !== 1 || out_dx !== px || out_dy !== py)) hold_ok = 0;
      pv = out_valid; pr = out_ready; px = out_dx; py = out_dy;
      if (done) seen = 1; else tick();
    end
    checks++;
    if (!hold_ok) begin
      errors++; $display("FAIL bp_hold got unstable stalled beat, required stable");
    end
    checks++;
    if (!seen || beat_count !== 4 || sb.size() !== 0) begin
      errors++; $display("FAIL bp_count got done=%0b cnt=%0d left=%0d, required 1 4 0", seen, beat_count, sb.size());
    end
    tick();
  endtask

  task automatic test_restart_ignored();
    bit seen;
    out_ready = 0;
    do_start(2, 1, -1);
    tick();
    cfg_max_x = 5; cfg_max_y = 5; start = 1;
    tick();
    start = 0; cfg_max_x = 7; cfg_max_y = 3;
    @(negedge clock);
    checks++;
    if (out_valid !== 1 || out_dx !== 0 || out_dy !== 0) begin
      errors++; $display("FAIL restart_stall got v=%0b dx=%0d dy=%0d, required 1 0 0", out_valid, out_dx, out_dy);
    end
    tick();
    out_ready = 1;
    wait_done(50, seen);
    checks++;
    if (!seen || beat_count !== 6 || sb.size() !== 0) begin
      errors++; $display("FAIL restart_count got done=%0b cnt=%0d left=%0d, required 1 6 0", seen, beat_count, sb.size());
    end
    tick();
  endtask

  task automatic test_abort(input bit rdy_at_abort, input int exp_cnt, input string nm);
    bit done_seen = 0;
    out_ready = 1;
    do_start(3, 3, exp_cnt);
    tick(); tick();
    if (rdy_at_abort) begin
      abort = 1; tick(); abort = 0;
    end else begin
      out_ready = 0; abort = 1; tick(); abort = 0;
    end
    @(negedge clock);
    checks++;
    if (out_valid !== 0 || busy !== 0 || beat_count !== exp_cnt) begin
      errors++; $display("FAIL %s got v=%0b busy=%0b cnt=%0d, required 0 0 %0d", nm, out_valid, busy, beat_count, exp_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      if (done) done_seen = 1;
      @(negedge clock);
    end
    checks++;
    if (done_seen || sb.size() !== 0) begin
      errors++; $display("FAIL %s_nodone got done=%0b left=%0d, required 0 0", nm, done_seen, sb.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1;
    do_start(2, 2, 5);
    for (int i = 0; i < 5; i++) tick();
    @(negedge clock);
    checks++;
    if (out_dx !== 2 || out_dy !== 1) begin
      errors++; $display("FAIL rstmid_pos got dx=%0d dy=%0d, required 2 1", out_dx, out_dy);
    end
    reset = 1;
    tick();
    reset = 0;
    @(negedge clock);
    checks++;
    if (out_valid !== 0 || busy !== 0 || beat_count !== 0 || sb.size() !== 0) begin
      errors++; $display("FAIL rstmid got v=%0b busy=%0b cnt=%0d left=%0d, required 0 0 0 0", out_valid, busy, beat_count, sb.size());
    end
    tick();
    do_start(1, 0, -1);
    wait_done(20, seen);
    checks++;
    if (!seen || beat_count !== 2 || sb.size() !== 0) begin
      errors++; $display("FAIL rstmid_restart got done=%0b cnt=%0d left=%0d, required 1 2 0", seen, beat_count, sb.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic(2, 1, "basic");
    test_backpressure();
    test_basic(0, 0, "degenerate");
    test_restart_ignored();
    test_abort(1'b1, 3, "abort_xfer");
    test_abort(1'b0, 2, "abort_stall");
    test_reset_mid();
    test_basic(2, 2, "shape22");
    test_basic(2, 1, "shape21");
    test_basic(0, 3, "column");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish, required finish");
    $fatal(1);
  end
endmodule

// File: doc/raster_step_gen.md
Name: raster_step_gen

Overview:
- Parameterised raster-order coordinate generator.
- Drives the per-step (dx, dy) operand pair into the width/height offset adder stage: one coordinate pair per accepted beat, in X-major raster order over a configured rectangle.
- Sequential front end for that adder: start/abort control, valid/ready output handshake, completion pulse, beat counter.

Parameters:
- WIDTH, 10, bit width of the X coordinate (dx) and of cfg_max_x.
- HEIGHT, 11, bit width of the Y coordinate (dy) and of cfg_max_y.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- abort  input  1  terminate a running scan; no done pulse.
- cfg_max_x  input  WIDTH  last X index (inclusive); latched on accepted start.
- cfg_max_y  input  HEIGHT  last Y index (inclusive); latched on accepted start.
- out_valid  output  1  out_dx/out_dy/out_last are valid.
- out_ready  input  1  downstream accepts the beat.
- out_dx  output  WIDTH  current X coordinate.
- out_dy  output  HEIGHT  current Y coordinate.
- out_last  output  1  current beat is (max_x, max_y).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last beat transfers.
- beat_count  output  WIDTH+HEIGHT  beats transferred since the last accepted start.

Behaviour:
- Reset (synchronous, high): state=IDLE, x=0, y=0, max regs=0, beat_count=0, out_valid=0, done=0, busy=0. Reset overrides all other inputs, including mid-scan.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch cfg_max_x/cfg_max_y; x=0, y=0, beat_count=0; go to RUN.
  - out_valid rises the cycle after start (1-cycle latency).
- IDLE, start=0: hold; beat_count keeps its last value.
- RUN outputs: out_valid=1, out_dx=x, out_dy=y, out_last=(x==max_x && y==max_y).
- Handshake: a beat transfers on a clock edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_dx/out_dy/out_last hold stable.
  - out_valid never drops in RUN without a transfer or abort.
- On transfer:
  - beat_count increments.
  - If out_last: go to DONE.
  - Else if x==max_x: x=0, y=y+1.
  - Else: x=x+1.
- Coordinate arithmetic: no wrap beyond the max registers, since x<=max_x and y<=max_y always hold.
- beat_count: total beats = (max_x+1)*(max_y+1) ≤ 2^(WIDTH+HEIGHT); saturates at all-ones and never wraps.
- DONE: out_valid=0, done=1 for exactly one cycle, busy=1; next state IDLE.
- start while RUN or DONE: ignored; the latched max values do not change.
- cfg_max_x/cfg_max_y changes outside accepted start have no effect.
- abort in RUN:
  - next state IDLE, out_valid=0 next cycle, done stays 0.
  - If a transfer coincides with abort, that beat counts (beat_count increments); abort still wins the state transition, even if the beat is out_last.
- abort in IDLE or DONE: ignored (DONE still pulses and returns to IDLE).
- Degenerate rectangle cfg_max_x=0, cfg_max_y=0: exactly one beat (0,0) with out_last=1.

Optional Feature:
- Macro: RASTER_STEP_GEN_SERPENTINE_EN.
- Defined:
  - Odd rows traverse X descending: row y odd starts at x=max_x and steps x-1 down to 0; even rows ascend.
  - Row change occurs at the row-end X (max_x on even rows, 0 on odd rows); x does not reset on row change.
  - out_last asserts at the final beat of row max_y: x=max_x if max_y even, x=0 if max_y odd.
- Not defined: plain raster order as described above; the serpentine logic is absent.

Test Plan:
- Basic scan: cfg_max_x=2, cfg_max_y=1, out_ready=1 -> beats (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), out_last only on (2,1); done pulses 1 cycle later; beat_count=6.
- Backpressure: cfg 3x0, out_ready toggled 1,0,0,1,... -> each coordinate holds while stalled; no coordinate skipped or duplicated; 4 beats total, beat_count=4.
- Degenerate and restart:
  - cfg 0,0 -> single beat (0,0) with out_last=1, then done.
  - start asserted during RUN with cfg 5,5 -> ignored; the original scan completes unchanged.
- Abort:
  - abort on the 3rd beat with out_ready=1 in a 4x4 scan -> beat_count=3, IDLE next cycle, done never asserted.
  - abort while out_ready=0 -> beat_count unchanged.
- Reset mid-scan: reset at (2,1) of a 3x3 scan -> next cycle out_valid=0, busy=0, beat_count=0; a new start scans from (0,0).
- Serpentine (macro defined): cfg_max_x=2, cfg_max_y=2 -> (0,0),(1,0),(2,0),(2,1),(1,1),(0,1),(0,2),(1,2),(2,2), out_last on (2,2); with cfg_max_y=1, out_last on (0,1).
